// File: rtl/bus_arbiter_pkg.sv
// Shared types and default widths for the bus arbiter and its clients.
package bus_arbiter_pkg;

  localparam int unsigned SLAVE_LEN_DEF = 2;
  localparam int unsigned BURST_LEN_DEF = 12;
  localparam int unsigned TIMEOUT_DEF   = 255;
  localparam int unsigned TMO_W         = 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_SLAVE = 2'd1,
    XFER       = 2'd2,
    RELEASE    = 2'd3
  } state_e;

  typedef enum logic {
    M1 = 1'b0,
    M2 = 1'b1
  } master_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between two bus masters, the slaves and the arbiter.
interface bus_arbiter_if
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned SLAVE_LEN = SLAVE_LEN_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF
);
  localparam int unsigned N_SLAVES = 1 << SLAVE_LEN;

  logic                 req_m1;
  logic                 req_m2;
  logic [BURST_LEN-1:0] burst_num_m1;
  logic [BURST_LEN-1:0] burst_num_m2;
  logic [SLAVE_LEN-1:0] slave_select_m1;
  logic [SLAVE_LEN-1:0] slave_select_m2;
  logic [N_SLAVES-1:0]  slave_ready;
  logic                 beat_done;
  logic                 grant_m1;
  logic                 grant_m2;
  logic [N_SLAVES-1:0]  slave_en;
  logic                 bus_busy;
  logic [BURST_LEN-1:0] beats_left;
  logic                 arb_error;

  // Arbiter side: takes requests and slave status, drives ownership.
  modport slave (
    input  req_m1, req_m2, burst_num_m1, burst_num_m2,
    input  slave_select_m1, slave_select_m2, slave_ready, beat_done,
    output grant_m1, grant_m2, slave_en, bus_busy, beats_left, arb_error
  );

  // Requester/environment side.
  modport master (
    output req_m1, req_m2, burst_num_m1, burst_num_m2,
    output slave_select_m1, slave_select_m2, slave_ready, beat_done,
    input  grant_m1, grant_m2, slave_en, bus_busy, beats_left, arb_error
  );

endinterface

// File: rtl/bus_arbiter_rr_select.sv
// Two-way round-robin pick: a tie goes to the master that was not granted last.
module rr_select
  import bus_arbiter_pkg::*;
(
  input  logic    req_m1,
  input  logic    req_m2,
  input  master_e last,
  output master_e winner,
  output logic    valid
);

  always_comb begin
    valid  = req_m1 | req_m2;
    winner = M1;
    if (req_m1 && req_m2) begin
      winner = (last == M1) ? M2 : M1;
    end else if (req_m2) begin
      winner = M2;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter: round-robin grant, slave wait, beat counting,
// idle timeout abort and a one-cycle release gap between owners.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned SLAVE_LEN = SLAVE_LEN_DEF,
  parameter int unsigned BURST_LEN = BURST_LEN_DEF,
  parameter int unsigned TIMEOUT   = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  localparam int unsigned          N_SLAVES = 1 << SLAVE_LEN;
  localparam logic [TMO_W-1:0]     TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [BURST_LEN-1:0] ONE_BEAT = BURST_LEN'(1);

  state_e               state_q, state_d;
  master_e              owner_q, owner_d;
  master_e              last_q, last_d;
  master_e              rr_winner;
  logic                 rr_valid;
  logic                 owner_req;
  logic                 slave_rdy;
  logic                 active_d;
  logic [SLAVE_LEN-1:0] sel_q, sel_d, req_sel;
  logic [BURST_LEN-1:0] beats_q, beats_d, req_burst;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 grant_m1_q, grant_m1_d;
  logic                 grant_m2_q, grant_m2_d;
  logic                 busy_q, busy_d;
  logic                 err_q, err_d;
  logic [N_SLAVES-1:0]  slave_en_q, slave_en_d;

  rr_select u_rr_select (
    .req_m1 (bus.req_m1),
    .req_m2 (bus.req_m2),
    .last   (last_q),
    .winner (rr_winner),
    .valid  (rr_valid)
  );

  assign owner_req = (owner_q == M1) ? bus.req_m1 : bus.req_m2;
  assign slave_rdy = bus.slave_ready[sel_q];
  assign req_sel   = (rr_winner == M1) ? bus.slave_select_m1 : bus.slave_select_m2;
  assign req_burst = (rr_winner == M1) ? bus.burst_num_m1 : bus.burst_num_m2;

  // Next state plus the next value of every registered output.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    sel_d   = sel_q;
    beats_d = beats_q;
    tmo_d   = tmo_q;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (rr_valid) begin
          state_d = WAIT_SLAVE;
          owner_d = rr_winner;
          sel_d   = req_sel;
          beats_d = (req_burst == '0) ? ONE_BEAT : req_burst;
          tmo_d   = '0;
        end
      end
      WAIT_SLAVE: begin
        if (!owner_req) begin
          state_d = RELEASE;
        end else if (slave_rdy) begin
          state_d = XFER;
          tmo_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          state_d = RELEASE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      XFER: begin
        if (!owner_req) begin
          state_d = RELEASE;
        end else if (bus.beat_done) begin
          tmo_d = '0;
          if (beats_q <= ONE_BEAT) begin
            state_d = RELEASE;
          end else begin
            beats_d = beats_q - ONE_BEAT;
          end
        end else if (tmo_q == TMO_LAST) begin
          state_d = RELEASE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      RELEASE: begin
        state_d = IDLE;
        last_d  = owner_q;
      end
      default: state_d = IDLE;
    endcase

    // The release gap always shows zero beats and a fresh timeout count.
    if (state_d == RELEASE) begin
      beats_d = '0;
      tmo_d   = '0;
    end

    active_d   = (state_d == WAIT_SLAVE) || (state_d == XFER);
    grant_m1_d = active_d && (owner_d == M1);
    grant_m2_d = active_d && (owner_d == M2);
    slave_en_d = active_d ? (N_SLAVES'(1) << sel_d) : '0;
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= M1;
      last_q     <= M2;
      sel_q      <= '0;
      beats_q    <= '0;
      tmo_q      <= '0;
      grant_m1_q <= 1'b0;
      grant_m2_q <= 1'b0;
      slave_en_q <= '0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      beats_q    <= beats_d;
      tmo_q      <= tmo_d;
      grant_m1_q <= grant_m1_d;
      grant_m2_q <= grant_m2_d;
      slave_en_q <= slave_en_d;
      busy_q     <= busy_d;
      err_q      <= err_d;
    end
  end

  assign bus.grant_m1   = grant_m1_q;
  assign bus.grant_m2   = grant_m2_q;
  assign bus.slave_en   = slave_en_q;
  assign bus.bus_busy   = busy_q;
  assign bus.beats_left = beats_q;
  assign bus.arb_error  = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios then random traffic, every cycle
// compared against a transaction-level model of ownership and beat counting.
module tb_bus_arbiter;

  localparam int unsigned SLAVE_LEN = 2;
  localparam int unsigned BURST_LEN = 12;
  localparam int unsigned TIMEOUT   = 255;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  // Model: owner 0 = nobody, 1 = m1, 2 = m2.
  int m_owner, m_slave, m_left, m_idle, m_last, m_rel_owner;
  bit m_xfer, m_release, m_err;

  bus_arbiter_if #(.SLAVE_LEN(SLAVE_LEN), .BURST_LEN(BURST_LEN)) bus ();

  bus_arbiter #(
    .SLAVE_LEN (SLAVE_LEN),
    .BURST_LEN (BURST_LEN),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_slave = 0; m_left = 0; m_idle = 0;
    m_last = 2; m_rel_owner = 0;
    m_xfer = 1'b0; m_release = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_finish(input bit e);
    m_release   = 1'b1;
    m_rel_owner = m_owner;
    m_owner     = 0;
    m_left      = 0;
    m_err       = e;
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    int   burst;
    logic oreq;
    m_err = 1'b0;
    if (!reset) begin
      model_reset();
      return;
    end
    if (m_release) begin
      m_release = 1'b0;
      m_last    = m_rel_owner;
    end else if (m_owner == 0) begin
      if (bus.req_m1 || bus.req_m2) begin
        if (bus.req_m1 && bus.req_m2) m_owner = (m_last == 1) ? 2 : 1;
        else                          m_owner = bus.req_m1 ? 1 : 2;
        m_slave = (m_owner == 1) ? int'(bus.slave_select_m1) : int'(bus.slave_select_m2);
        burst   = (m_owner == 1) ? int'(bus.burst_num_m1) : int'(bus.burst_num_m2);
        m_left  = (burst == 0) ? 1 : burst;
        m_idle  = 0;
        m_xfer  = 1'b0;
      end
    end else begin
      oreq = (m_owner == 1) ? bus.req_m1 : bus.req_m2;
      if (!oreq) begin
        model_finish(1'b0);
      end else if (!m_xfer) begin
        if (bus.slave_ready[m_slave]) begin
          m_xfer = 1'b1;
          m_idle = 0;
        end else begin
          m_idle++;
          if (m_idle >= int'(TIMEOUT)) model_finish(1'b1);
        end
      end else if (bus.beat_done) begin
        m_idle = 0;
        m_left--;
        if (m_left == 0) model_finish(1'b0);
      end else begin
        m_idle++;
        if (m_idle >= int'(TIMEOUT)) model_finish(1'b1);
      end
    end
  endtask

  task automatic check_all();
    check("grant_m1",   32'(bus.grant_m1),   32'(m_owner == 1));
    check("grant_m2",   32'(bus.grant_m2),   32'(m_owner == 2));
    check("slave_en",   32'(bus.slave_en),   (m_owner != 0) ? (32'd1 << m_slave) : 32'd0);
    check("bus_busy",   32'(bus.bus_busy),   32'((m_owner != 0) || m_release));
    check("beats_left", 32'(bus.beats_left), 32'(m_left));
    check("arb_error",  32'(bus.arb_error),  32'(m_err));
    check("grant_excl", 32'(bus.grant_m1 & bus.grant_m2), 32'd0);
  endtask

  // One clock: model steps on the edge, outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    #2 reset = 1'b1;
  endtask

  initial begin
    bus.req_m1 = 1'b0; bus.req_m2 = 1'b0;
    bus.burst_num_m1 = '0; bus.burst_num_m2 = '0;
    bus.slave_select_m1 = '0; bus.slave_select_m2 = '0;
    bus.slave_ready = '0; bus.beat_done = 1'b0;
    model_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all();
    #2 reset = 1'b1;

    // Single m1 burst of 3 to slave 1
    bus.req_m1 = 1'b1; bus.burst_num_m1 = 12'd3; bus.slave_select_m1 = 2'd1;
    bus.slave_ready = 4'b0010;
    cyc();
    check("t1_grant",    32'(bus.grant_m1),   32'd1);
    check("t1_slave_en", 32'(bus.slave_en),   32'h2);
    check("t1_beats3",   32'(bus.beats_left), 32'd3);
    cyc();
    bus.beat_done = 1'b1;
    cyc();
    check("t1_beats2", 32'(bus.beats_left), 32'd2);
    cyc();
    check("t1_beats1", 32'(bus.beats_left), 32'd1);
    cyc();
    check("t1_release_grant", 32'(bus.grant_m1), 32'd0);
    check("t1_release_busy",  32'(bus.bus_busy), 32'd1);
    bus.beat_done = 1'b0; bus.req_m1 = 1'b0;
    cyc();
    check("t1_idle_busy", 32'(bus.bus_busy), 32'd0);

    // Ties after reset: m1, then m2, then m1 again
    do_reset();
    bus.req_m1 = 1'b1; bus.req_m2 = 1'b1;
    bus.burst_num_m1 = 12'd1; bus.burst_num_m2 = 12'd1;
    bus.slave_select_m1 = 2'd0; bus.slave_select_m2 = 2'd3;
    bus.slave_ready = 4'b1111;
    cyc();
    check("t2_first_m1", 32'(bus.grant_m1), 32'd1);
    cyc();
    bus.beat_done = 1'b1;
    cyc();
    bus.beat_done = 1'b0;
    cyc();
    cyc();
    check("t2_second_m2", 32'(bus.grant_m2), 32'd1);
    check("t2_slave_en3", 32'(bus.slave_en), 32'h8);
    cyc();
    bus.beat_done = 1'b1;
    cyc();
    bus.beat_done = 1'b0;
    cyc();
    cyc();
    check("t2_third_m1", 32'(bus.grant_m1), 32'd1);
    bus.req_m1 = 1'b0; bus.req_m2 = 1'b0;
    cyc();
    cyc();

    // m2 waits on slave 2 that never becomes ready
    bus.req_m2 = 1'b1; bus.burst_num_m2 = 12'd2; bus.slave_select_m2 = 2'd2;
    bus.slave_ready = 4'b1011;
    cyc();
    check("t3_grant_m2", 32'(bus.grant_m2), 32'd1);
    for (int i = 1; i < int'(TIMEOUT); i++) cyc();
    check("t3_no_early_err", 32'(bus.arb_error), 32'd0);
    cyc();
    check("t3_arb_error", 32'(bus.arb_error), 32'd1);
    check("t3_grant_off", 32'(bus.grant_m2),  32'd0);
    bus.req_m2 = 1'b0;
    cyc();
    check("t3_err_pulse", 32'(bus.arb_error), 32'd0);
    check("t3_idle",      32'(bus.bus_busy),  32'd0);

    // m1 burst 4 abandoned after two beats
    bus.req_m1 = 1'b1; bus.burst_num_m1 = 12'd4; bus.slave_select_m1 = 2'd0;
    bus.slave_ready = 4'b0001;
    cyc();
    cyc();
    bus.beat_done = 1'b1;
    cyc();
    cyc();
    check("t4_beats2", 32'(bus.beats_left), 32'd2);
    bus.beat_done = 1'b0; bus.req_m1 = 1'b0;
    cyc();
    check("t4_release_err",   32'(bus.arb_error),  32'd0);
    check("t4_release_beats", 32'(bus.beats_left), 32'd0);
    check("t4_release_busy",  32'(bus.bus_busy),   32'd1);
    cyc();

    // Asynchronous reset in the middle of a burst, m2 pending
    bus.req_m1 = 1'b1; bus.burst_num_m1 = 12'd7; bus.slave_select_m1 = 2'd1;
    bus.slave_ready = 4'b1111;
    cyc();
    cyc();
    bus.req_m2 = 1'b1; bus.burst_num_m2 = 12'd1; bus.slave_select_m2 = 2'd3;
    bus.beat_done = 1'b1;
    cyc();
    cyc();
    check("t5_beats5", 32'(bus.beats_left), 32'd5);
    bus.beat_done = 1'b0;
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all();
    check("t5_async_beats", 32'(bus.beats_left), 32'd0);
    bus.req_m1 = 1'b0;
    cyc();
    #2 reset = 1'b1;
    cyc();
    check("t5_m2_after_reset", 32'(bus.grant_m2), 32'd1);
    cyc();
    bus.beat_done = 1'b1;
    cyc();
    bus.beat_done = 1'b0; bus.req_m2 = 1'b0;
    cyc();

    // Zero burst length means one beat; stray beat_done in IDLE is ignored
    bus.req_m1 = 1'b1; bus.burst_num_m1 = 12'd0; bus.slave_select_m1 = 2'd2;
    cyc();
    check("t6_beats1", 32'(bus.beats_left), 32'd1);
    cyc();
    bus.beat_done = 1'b1;
    cyc();
    check("t6_done", 32'(bus.grant_m1), 32'd0);
    bus.req_m1 = 1'b0;
    cyc();
    cyc();
    check("t6_idle_beats", 32'(bus.beats_left), 32'd0);
    check("t6_idle_busy",  32'(bus.bus_busy),   32'd0);
    bus.beat_done = 1'b0;

    // Random traffic against the model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 15) == 0) bus.req_m1 = ~bus.req_m1;
      if ($urandom_range(0, 15) == 0) bus.req_m2 = ~bus.req_m2;
      bus.burst_num_m1    = 12'($urandom_range(0, 4));
      bus.burst_num_m2    = 12'($urandom_range(0, 4));
      bus.slave_select_m1 = 2'($urandom_range(0, 3));
      bus.slave_select_m2 = 2'($urandom_range(0, 3));
      bus.slave_ready     = 4'($urandom | $urandom);
      bus.beat_done       = ($urandom_range(0, 2) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
